func_axis_join_fork: RTL and testbench
======================================

Name: func_axis_join_fork

Overview:
- Parametrised AXI-Stream adapter between the SDx shell and the TyBEC-generated `main` kernel. Replaces the fixed 2-in/1-out combinational wrapper.
- Gives each input channel its own FIFO and joins the inputs into the kernel's single ivalid/iready handshake.
- Forks the kernel's single ovalid/oready handshake into C_NUM_OUT independent AXI-Stream outputs, each with its own FIFO.
- Makes s_tready independent of s_tvalid, so the shell sees AXI-compliant handshakes.

Parameters:
- C_DATA_WIDTH, 32, width of one channel word (32*TY_GVECT, maximum 512).
- C_NUM_IN, 2, number of input channels, 1..8.
- C_NUM_OUT, 1, number of output channels, 1..4.
- C_FIFO_DEPTH, 4, entries per channel FIFO; power of two, 2..64.

Ports:
- aclk  in  1  clock.
- areset_n  in  1  asynchronous active-low reset.
- s_tvalid  in  C_NUM_IN  per-channel input valid.
- s_tdata  in  C_NUM_IN x C_DATA_WIDTH  per-channel input data (packed).
- s_tready  out  C_NUM_IN  per-channel input ready.
- k_ivalid  out  1  joined valid to the kernel.
- k_idata  out  C_NUM_IN x C_DATA_WIDTH  FIFO heads presented to the kernel.
- k_iready  in  1  back-pressure from the kernel.
- k_ovalid  in  1  kernel output valid.
- k_odata  in  C_NUM_OUT x C_DATA_WIDTH  kernel output data.
- k_oready  out  1  ready to the kernel.
- m_tvalid  out  C_NUM_OUT  per-channel output valid.
- m_tdata  out  C_NUM_OUT x C_DATA_WIDTH  per-channel output data.
- m_tready  in  C_NUM_OUT  per-channel sink ready.

Behaviour:
- Reset:
  - areset_n low clears all FIFO pointers and occupancy counts immediately (asynchronously); contents are discarded.
  - While reset is asserted: s_tready=0, k_ivalid=0, k_oready=0, m_tvalid=0, k_idata=0, m_tdata=0.
  - On the first rising edge after deassertion, s_tready and k_oready go to 1.
- Channel FIFO (all instances):
  - First-word-fall-through.
  - Push when valid & ready; the pushed word is visible at the head on the next cycle. There is no same-cycle bypass, so empty-to-output latency is 1 cycle.
  - Ready = not full, registered from the count. No dependence on the upstream valid.
  - Simultaneous push and pop when not full: count unchanged.
  - When full: ready is 0 and a pop in that cycle re-asserts ready the following cycle. No pass-through when full.
  - Read and write pointers are log2(C_FIFO_DEPTH) bits and wrap naturally. The count is log2(C_FIFO_DEPTH)+1 bits, range 0..C_FIFO_DEPTH.
- Input join:
  - s_tready[i] = input FIFO i not full.
  - k_ivalid = AND of every input FIFO non-empty.
  - k_idata[i] = head of input FIFO i.
  - On k_ivalid & k_iready, every input FIFO pops one word in the same cycle.
  - Channels fill independently, so skew between channels is absorbed up to C_FIFO_DEPTH words.
- Output fork:
  - k_oready = AND of every output FIFO not full.
  - On k_ovalid & k_oready, k_odata[j] is pushed into output FIFO j for every j at once.
  - m_tvalid[j] = output FIFO j non-empty; m_tdata[j] = its head.
  - Each output pops independently on m_tvalid[j] & m_tready[j].
  - A stalled output j back-pressures the kernel only once FIFO j is full.
- Word order is preserved per channel. No word is ever dropped or duplicated.
- Throughput: 1 word per cycle per channel when no channel is stalled.
- Reset mid-stream: in-flight words are lost. The kernel is reset by the same areset_n.

Optional Feature:
- Macro: TY_AXIS_PERF_CNT_EN.
- Defined:
  - Adds 32-bit saturating counters and output ports perf_in_stall (count of k_iready=0 & all inputs non-empty) and perf_out_stall (count of k_ovalid=1 & k_oready=0).
  - Both counters clear on reset.
- Undefined: no counters and no ports; logic is identical otherwise.

Decomposition:
- Package ty_axis_pkg holds:
  - typedef word_t [C_DATA_WIDTH-1:0];
  - localparam CNT_W = $clog2(C_FIFO_DEPTH)+1;
  - PERF_W = 32.
- Sub-module ty_sfifo: parametrised FWFT FIFO (width, depth) with push/pop/full/empty/count. It is instantiated C_NUM_IN + C_NUM_OUT times via generate loops.

Test Plan:
- Reset: hold areset_n low for 3 cycles with s_tvalid=all ones → s_tready=0, m_tvalid=0, k_ivalid=0 throughout; s_tready=all ones on the 1st edge after release.
- Skew: C_NUM_IN=2; push 4 words 0x10..0x13 on channel 0 only, then 0x20 on channel 1 → k_ivalid stays 0 until 1 cycle after 0x20 is accepted; then k_idata={0x20,0x10}.
- Full boundary: C_FIFO_DEPTH=4, k_iready=0, stream 6 words on both channels → s_tready drops after 4 accepts; raising k_iready for 1 cycle re-asserts s_tready 1 cycle later; exactly 4 words are held.
- Fork stall: C_NUM_OUT=2, m_tready[1]=0, kernel emits 0x1..0x6 → m_tdata[0] delivers all 6 in order only as space allows; k_oready=0 after 4 pushes; releasing m_tready[1] drains 0x1..0x6 on channel 1 in order.
- Streaming: random valid/ready at 50% on all ports, 1000 words through a loopback kernel (k_odata = k_idata[0] + k_idata[1]) → outputs match the scoreboard with no drops or duplicates.
- Perf (macro on): k_iready held at 0 for 10 cycles with inputs full → perf_in_stall=10.

Source files
------------

// File: rtl/ty_axis_pkg.sv
// Shared types and constants for the SDx shell <-> TyBEC kernel AXI-Stream adapter.
// Default-width helpers live here; the modules carry their own width/depth parameters.
package ty_axis_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 4;

  typedef logic [DEF_DATA_WIDTH-1:0] word_t;

  localparam int CNT_W  = $clog2(DEF_FIFO_DEPTH) + 1;
  localparam int PERF_W = 32;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + {{(PERF_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/ty_sfifo.sv
// First-word-fall-through channel FIFO.
// A pushed word is visible at the head one cycle later (no same-cycle bypass).
// "full" comes from a register updated from the next count, so the upstream
// ready never depends on the upstream valid. It reads full while in reset.
module ty_sfifo
  import ty_axis_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    cnt;
  logic [PTR_W:0]    cnt_next;
  logic              rdy;
  logic              do_push;
  logic              do_pop;

  assign do_push = push & rdy;
  assign do_pop  = pop & (cnt != '0);
  assign empty   = (cnt == '0);
  assign full    = ~rdy;
  // An empty FIFO presents zero so nothing stale leaks out after reset.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  // Occupancy after this cycle's push/pop; a simultaneous pair leaves it unchanged.
  always_comb begin
    cnt_next = cnt;
    if (do_push && !do_pop) begin
      cnt_next = cnt + CNT_ONE;
    end else if (!do_push && do_pop) begin
      cnt_next = cnt - CNT_ONE;
    end
  end

  // Pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      rdy    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      cnt <= cnt_next;
      rdy <= (cnt_next != FULL_CNT);
    end
  end

  // Storage is not reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/func_axis_join_fork.sv
// AXI-Stream join/fork adapter between the SDx shell and the TyBEC `main` kernel.
// Each input channel is buffered and the heads are joined into one kernel
// handshake; the kernel output is forked into independently buffered outputs.
// Optional build macro TY_AXIS_PERF_CNT_EN adds saturating stall counters
// (perf_in_stall, perf_out_stall).
module func_axis_join_fork
  import ty_axis_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_NUM_IN     = 2,
  parameter int C_NUM_OUT    = 1,
  parameter int C_FIFO_DEPTH = 4
) (
  input  logic                              aclk,
  input  logic                              areset_n,
  input  logic [C_NUM_IN-1:0]               s_tvalid,
  input  logic [C_NUM_IN*C_DATA_WIDTH-1:0]  s_tdata,
  output logic [C_NUM_IN-1:0]               s_tready,
  output logic                              k_ivalid,
  output logic [C_NUM_IN*C_DATA_WIDTH-1:0]  k_idata,
  input  logic                              k_iready,
  input  logic                              k_ovalid,
  input  logic [C_NUM_OUT*C_DATA_WIDTH-1:0] k_odata,
  output logic                              k_oready,
  output logic [C_NUM_OUT-1:0]              m_tvalid,
  output logic [C_NUM_OUT*C_DATA_WIDTH-1:0] m_tdata,
  input  logic [C_NUM_OUT-1:0]              m_tready
`ifdef TY_AXIS_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]                 perf_in_stall,
  output logic [PERF_W-1:0]                 perf_out_stall
`endif
);

  logic [C_NUM_IN-1:0]  in_full;
  logic [C_NUM_IN-1:0]  in_empty;
  logic [C_NUM_OUT-1:0] out_full;
  logic [C_NUM_OUT-1:0] out_empty;
  logic                 join_fire;
  logic                 fork_fire;

  // Join: the kernel sees a word only when every channel has one queued.
  assign k_ivalid  = ~|in_empty;
  assign join_fire = k_ivalid & k_iready;

  // Fork: accept from the kernel only when every output channel has room.
  assign k_oready  = ~|out_full;
  assign fork_fire = k_ovalid & k_oready;

  for (genvar i = 0; i < C_NUM_IN; i++) begin : g_in
    ty_sfifo #(
      .DATA_W (C_DATA_WIDTH),
      .DEPTH  (C_FIFO_DEPTH)
    ) u_fifo (
      .clk   (aclk),
      .rst_n (areset_n),
      .push  (s_tvalid[i]),
      .wdata (s_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH]),
      .full  (in_full[i]),
      .pop   (join_fire),
      .rdata (k_idata[i*C_DATA_WIDTH +: C_DATA_WIDTH]),
      .empty (in_empty[i])
    );
    assign s_tready[i] = ~in_full[i];
  end

  for (genvar j = 0; j < C_NUM_OUT; j++) begin : g_out
    ty_sfifo #(
      .DATA_W (C_DATA_WIDTH),
      .DEPTH  (C_FIFO_DEPTH)
    ) u_fifo (
      .clk   (aclk),
      .rst_n (areset_n),
      .push  (fork_fire),
      .wdata (k_odata[j*C_DATA_WIDTH +: C_DATA_WIDTH]),
      .full  (out_full[j]),
      .pop   (m_tready[j]),
      .rdata (m_tdata[j*C_DATA_WIDTH +: C_DATA_WIDTH]),
      .empty (out_empty[j])
    );
    assign m_tvalid[j] = ~out_empty[j];
  end

`ifdef TY_AXIS_PERF_CNT_EN
  // Count cycles where data waits on the kernel, and where the kernel waits on the outputs.
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      perf_in_stall  <= '0;
      perf_out_stall <= '0;
    end else begin
      if (k_ivalid && !k_iready) perf_in_stall  <= sat_inc(perf_in_stall);
      if (k_ovalid && !k_oready) perf_out_stall <= sat_inc(perf_out_stall);
    end
  end
`endif

endmodule

// File: tb/tb_func_axis_join_fork.sv
// Bench for func_axis_join_fork: reset, input join table, output fork stall,
// randomised loopback streaming with a scoreboard, and (when built with
// TY_AXIS_PERF_CNT_EN) the stall counters.
module tb_func_axis_join_fork;

  localparam int W  = 32;
  localparam int NI = 2;
  localparam int NO = 2;
  localparam int D  = 4;
  localparam int N  = 1000;

  logic            aclk = 1'b0;
  logic            areset_n;
  logic [NI-1:0]   s_tvalid;
  logic [NI*W-1:0] s_tdata;
  logic [NI-1:0]   s_tready;
  logic            k_ivalid;
  logic [NI*W-1:0] k_idata;
  logic            k_iready;
  logic            k_ovalid;
  logic [NO*W-1:0] k_odata;
  logic            k_oready;
  logic [NO-1:0]   m_tvalid;
  logic [NO*W-1:0] m_tdata;
  logic [NO-1:0]   m_tready;
`ifdef TY_AXIS_PERF_CNT_EN
  logic [31:0]     perf_in_stall;
  logic [31:0]     perf_out_stall;
`endif

  int total = 0;
  int bad   = 0;

  logic            loop_mode = 1'b0;
  logic            kr        = 1'b0;
  logic            drv_kir   = 1'b0;
  logic            drv_kov   = 1'b0;
  logic [NO*W-1:0] drv_kod   = '0;

  always #5 aclk = ~aclk;

  // Kernel stand-in: either driven directly by the bench or a loopback.
  always_comb begin
    k_iready = drv_kir;
    k_ovalid = drv_kov;
    k_odata  = drv_kod;
    if (loop_mode) begin
      k_iready = k_oready & kr;
      k_ovalid = k_ivalid & kr;
      k_odata  = {k_idata[2*W-1:W] ^ k_idata[W-1:0], k_idata[2*W-1:W] + k_idata[W-1:0]};
    end
  end

  func_axis_join_fork #(
    .C_DATA_WIDTH (W),
    .C_NUM_IN     (NI),
    .C_NUM_OUT    (NO),
    .C_FIFO_DEPTH (D)
  ) dut (
    .aclk     (aclk),
    .areset_n (areset_n),
    .s_tvalid (s_tvalid),
    .s_tdata  (s_tdata),
    .s_tready (s_tready),
    .k_ivalid (k_ivalid),
    .k_idata  (k_idata),
    .k_iready (k_iready),
    .k_ovalid (k_ovalid),
    .k_odata  (k_odata),
    .k_oready (k_oready),
    .m_tvalid (m_tvalid),
    .m_tdata  (m_tdata),
    .m_tready (m_tready)
`ifdef TY_AXIS_PERF_CNT_EN
    ,
    .perf_in_stall  (perf_in_stall),
    .perf_out_stall (perf_out_stall)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  v;
    logic [31:0] d0;
    logic [31:0] d1;
    logic        kir;
    logic [1:0]  rdy;
    logic        iv;
    logic [31:0] h0;
    logic [31:0] h1;
  } vec_t;

  vec_t tbl[32];
  int   n_vec = 0;

  task automatic add(input logic [1:0] v, input logic [31:0] d0, input logic [31:0] d1,
                     input logic kir, input logic [1:0] rdy, input logic iv,
                     input logic [31:0] h0, input logic [31:0] h1);
    tbl[n_vec] = '{v, d0, d1, kir, rdy, iv, h0, h1};
    n_vec++;
  endtask

  logic [31:0] q0[$], q1[$], e0[$], e1[$];

  initial begin
    int idx, got0, got1, sent0, sent1, cyc;
    logic [31:0] pend0, pend1, a, b;

    // skew: four words on channel 0, then one on channel 1
    add(2'b01, 32'h10, 0, 0, 2'b11, 0, 0, 0);
    add(2'b01, 32'h11, 0, 0, 2'b11, 0, 0, 0);
    add(2'b01, 32'h12, 0, 0, 2'b11, 0, 0, 0);
    add(2'b01, 32'h13, 0, 0, 2'b11, 0, 0, 0);
    add(2'b10, 0, 32'h20, 0, 2'b10, 0, 0, 0);
    add(2'b00, 0, 0,      0, 2'b10, 1, 32'h10, 32'h20);
    add(2'b00, 0, 0,      1, 2'b10, 1, 32'h10, 32'h20);
    // drain the rest of channel 0 against new channel-1 words
    add(2'b10, 0, 32'h21, 1, 2'b11, 0, 0, 0);
    add(2'b10, 0, 32'h22, 1, 2'b11, 1, 32'h11, 32'h21);
    add(2'b10, 0, 32'h23, 1, 2'b11, 1, 32'h12, 32'h22);
    add(2'b00, 0, 0,      1, 2'b11, 1, 32'h13, 32'h23);
    add(2'b00, 0, 0,      0, 2'b11, 0, 0, 0);
    // full boundary with the kernel stalled
    add(2'b11, 32'h30, 32'h40, 0, 2'b11, 0, 0, 0);
    add(2'b11, 32'h31, 32'h41, 0, 2'b11, 1, 32'h30, 32'h40);
    add(2'b11, 32'h32, 32'h42, 0, 2'b11, 1, 32'h30, 32'h40);
    add(2'b11, 32'h33, 32'h43, 0, 2'b11, 1, 32'h30, 32'h40);
    add(2'b11, 32'h34, 32'h44, 0, 2'b00, 1, 32'h30, 32'h40);
    add(2'b11, 32'h34, 32'h44, 1, 2'b00, 1, 32'h30, 32'h40);
    add(2'b11, 32'h34, 32'h44, 0, 2'b11, 1, 32'h31, 32'h41);
    add(2'b11, 32'h35, 32'h45, 0, 2'b00, 1, 32'h31, 32'h41);
    add(2'b00, 0, 0,      0, 2'b00, 1, 32'h31, 32'h41);
    add(2'b00, 0, 0,      1, 2'b00, 1, 32'h31, 32'h41);
    add(2'b00, 0, 0,      1, 2'b11, 1, 32'h32, 32'h42);
    add(2'b00, 0, 0,      1, 2'b11, 1, 32'h33, 32'h43);
    add(2'b00, 0, 0,      1, 2'b11, 1, 32'h34, 32'h44);
    add(2'b00, 0, 0,      0, 2'b11, 0, 0, 0);

    // reset held with inputs requesting
    areset_n = 1'b0;
    s_tvalid = 2'b11;
    s_tdata  = {32'hAAAA5555, 32'h5555AAAA};
    m_tready = 2'b11;
    repeat (3) begin
      @(negedge aclk); #1;
      check("rst_s_tready", s_tready, 0);
      check("rst_k_ivalid", k_ivalid, 0);
      check("rst_k_oready", k_oready, 0);
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_k_idata",  k_idata,  0);
      check("rst_m_tdata",  m_tdata,  0);
    end
    @(negedge aclk);
    areset_n = 1'b1;
    s_tvalid = 2'b00;
    @(negedge aclk); #1;
    check("rel_s_tready", s_tready, 2'b11);
    check("rel_k_oready", k_oready, 1);

    // join table
    for (int i = 0; i < n_vec; i++) begin
      @(negedge aclk);
      s_tvalid = tbl[i].v;
      s_tdata  = {tbl[i].d1, tbl[i].d0};
      drv_kir  = tbl[i].kir;
      #1;
      check($sformatf("vec%0d_s_tready", i), s_tready, tbl[i].rdy);
      check($sformatf("vec%0d_k_ivalid", i), k_ivalid, tbl[i].iv);
      if (tbl[i].iv) check($sformatf("vec%0d_k_idata", i), k_idata, {tbl[i].h1, tbl[i].h0});
    end
    s_tvalid = 2'b00;
    drv_kir  = 1'b0;

    // fork with output 1 stalled for the first 8 cycles
    m_tready = 2'b01;
    idx = 0; got0 = 0; got1 = 0;
    for (int c = 0; c < 60 && (got0 < 6 || got1 < 6); c++) begin
      @(negedge aclk);
      if (c == 8) m_tready = 2'b11;
      drv_kov = (idx < 6);
      drv_kod = {32'(idx + 1), 32'(idx + 1)};
      #1;
      if (c >= 4 && c < 8) begin
        check("fork_k_oready_stall", k_oready, 0);
        check("fork_m1_held", m_tvalid[1], 1);
      end
      if (m_tvalid[0] && m_tready[0]) begin got0++; check("fork_m0_data", m_tdata[W-1:0], got0); end
      if (m_tvalid[1] && m_tready[1]) begin got1++; check("fork_m1_data", m_tdata[2*W-1:W], got1); end
      if (drv_kov && k_oready) idx++;
    end
    check("fork_m0_count", got0, 6);
    check("fork_m1_count", got1, 6);
    drv_kov  = 1'b0;
    m_tready = 2'b11;

    // randomised loopback streaming
    loop_mode = 1'b1;
    got0 = 0; got1 = 0; sent0 = 0; sent1 = 0; cyc = 0;
    pend0 = $urandom; pend1 = $urandom;
    while ((got0 < N || got1 < N) && cyc < 20000) begin
      @(negedge aclk);
      cyc++;
      s_tvalid[0] = (sent0 < N) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_tvalid[1] = (sent1 < N) ? 1'($urandom_range(0, 1)) : 1'b0;
      s_tdata     = {pend1, pend0};
      m_tready    = 2'($urandom_range(0, 3));
      kr          = 1'($urandom_range(0, 1));
      #1;
      if (s_tvalid[0] && s_tready[0]) begin q0.push_back(pend0); sent0++; pend0 = $urandom; end
      if (s_tvalid[1] && s_tready[1]) begin q1.push_back(pend1); sent1++; pend1 = $urandom; end
      while (q0.size() > 0 && q1.size() > 0) begin
        a = q0.pop_front();
        b = q1.pop_front();
        e0.push_back(a + b);
        e1.push_back(a ^ b);
      end
      if (m_tvalid[0] && m_tready[0]) begin
        if (e0.size() == 0) check("stream_m0_extra", 1, 0);
        else check("stream_m0", m_tdata[W-1:0], e0.pop_front());
        got0++;
      end
      if (m_tvalid[1] && m_tready[1]) begin
        if (e1.size() == 0) check("stream_m1_extra", 1, 0);
        else check("stream_m1", m_tdata[2*W-1:W], e1.pop_front());
        got1++;
      end
    end
    check("stream_m0_count", got0, N);
    check("stream_m1_count", got1, N);
    check("stream_m0_left", e0.size(), 0);
    check("stream_m1_left", e1.size(), 0);
    loop_mode = 1'b0;
    kr        = 1'b0;
    s_tvalid  = 2'b00;
    m_tready  = 2'b11;
    repeat (3) @(negedge aclk);
    #1;
    check("stream_drained_m", m_tvalid, 0);
    check("stream_drained_k", k_ivalid, 0);

`ifdef TY_AXIS_PERF_CNT_EN
    // stall counters from a fresh reset
    @(negedge aclk);
    areset_n = 1'b0;
    drv_kir  = 1'b0;
    drv_kov  = 1'b0;
    @(negedge aclk);
    areset_n = 1'b1;
    repeat (4) begin
      @(negedge aclk);
      s_tvalid = 2'b11;
      s_tdata  = {32'h77, 32'h66};
    end
    @(negedge aclk);
    s_tvalid = 2'b00;
    #1;
    check("perf_in_fill", perf_in_stall, 3);
    check("perf_full_rdy", s_tready, 2'b00);
    repeat (10) @(negedge aclk);
    #1;
    check("perf_in_10", perf_in_stall, 13);
    check("perf_out_idle", perf_out_stall, 0);
    drv_kov  = 1'b1;
    drv_kod  = {32'h9, 32'h8};
    m_tready = 2'b00;
    repeat (6) @(negedge aclk);
    #1;
    check("perf_out_2", perf_out_stall, 2);
    check("perf_in_19", perf_in_stall, 19);
    drv_kov = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
